// File: rtl/jpeg_quant_seq.sv
// jpeg_quant_seq
//   Walks one 8x8 block (32 packed words, two signed 16-bit coefficients per
//   word) from the DCT result buffer through the external dual-lane quantizer.
//   The quantized words go to the quantized-block buffer. Software pulses
//   start_i once per block.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 start one block (only honoured in IDLE)
//   hold_i                  output buffer busy: freezes the whole pipeline
//   busy_o, done_o          block in progress / one-cycle completion pulse
//   src_addr_o, src_re_o    DCT buffer read port (sync RAM, 1-cycle latency)
//   src_data_i              coefficient word {lane1, lane2}
//   rec_addr_o, rec_re_o    reciprocal table read port (mirrors src port)
//   rec_data_i              reciprocal word {lane1, lane2}
//   q_x_o, q_rec1_o/2_o     operands to the combinational quantizer
//   q_x_i                   quantizer result
//   dst_addr_o, dst_data_o  registered write address / data
//   dst_we_o                output buffer write strobe
//
// Flow control: hold_i is a stall with no valid/ready pairing. While it is
// high, no read is issued and every pipeline register keeps its value. The
// source RAMs keep their outputs because re stays low. A word in stage C is
// written on the first cycle with hold_i low.

module jpeg_quant_seq #(
   parameter int WORDS = 32,
   parameter int AW    = 5
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          hold_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [AW-1:0] src_addr_o,
   output logic          src_re_o,
   input  logic [31:0]   src_data_i,
   output logic [AW-1:0] rec_addr_o,
   output logic          rec_re_o,
   input  logic [31:0]   rec_data_i,
   output logic [31:0]   q_x_o,
   output logic [15:0]   q_rec1_o,
   output logic [15:0]   q_rec2_o,
   input  logic [31:0]   q_x_i,
   output logic [AW-1:0] dst_addr_o,
   output logic [31:0]   dst_data_o,
   output logic          dst_we_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] rd_cnt_q, rd_cnt_d;

   // Stage B: the RAM output is valid for the word read last cycle.
   logic          vld_b_q;
   logic [AW-1:0] addr_b_q;
   // Stage C: registered quantizer result waiting for its write strobe.
   logic          vld_c_q;
   logic [AW-1:0] dst_addr_q;
   logic [31:0]   dst_data_q;

   logic          issue;

   assign issue = (state_q == S_RUN) && !hold_i;

   always_comb begin
      state_d  = state_q;
      rd_cnt_d = rd_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d  = S_RUN;
               rd_cnt_d = '0;
            end
         end
         S_RUN: begin
            if (issue) begin
               rd_cnt_d = rd_cnt_q + AW'(1);
               if (rd_cnt_q == AW'(WORDS - 1)) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            // Stage B is already empty. An unheld edge moves the stage-C
            // word out through its write, so both stages are empty after
            // this edge.
            if (!hold_i && !vld_b_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         rd_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_b_q    <= 1'b0;
         addr_b_q   <= '0;
         vld_c_q    <= 1'b0;
         dst_addr_q <= '0;
         dst_data_q <= '0;
      end else if (!hold_i) begin
         vld_b_q <= issue;
         if (issue) begin
            addr_b_q <= rd_cnt_q;
         end
         vld_c_q <= vld_b_q;
         if (vld_b_q) begin
            dst_addr_q <= addr_b_q;
            dst_data_q <= q_x_i;
         end
      end
   end

   assign busy_o     = (state_q != S_IDLE);
   assign done_o     = (state_q == S_DONE);
   assign src_addr_o = rd_cnt_q;
   assign rec_addr_o = rd_cnt_q;
   assign src_re_o   = issue;
   assign rec_re_o   = issue;
   assign q_x_o      = src_data_i;
   assign q_rec1_o   = rec_data_i[31:16];
   assign q_rec2_o   = rec_data_i[15:0];
   assign dst_addr_o = dst_addr_q;
   assign dst_data_o = dst_data_q;
   assign dst_we_o   = vld_c_q && !hold_i;

endmodule

// File: tb/tb_jpeg_quant_seq.sv
// tb_jpeg_quant_seq
//   Bench for jpeg_quant_seq. It models the two source RAMs, the external
//   quantizer and an expected-word queue built from the quantizer contract.

module tb_jpeg_quant_seq;
   localparam int WORDS   = 32;
   localparam int AW      = 5;
   localparam int M_PLAIN = 0;
   localparam int M_HOLD  = 1;
   localparam int M_RHOLD = 2;
   localparam int M_START = 3;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic          hold_i = 1'b0;
   logic          busy_o, done_o, src_re_o, rec_re_o, dst_we_o;
   logic [AW-1:0] src_addr_o, rec_addr_o, dst_addr_o;
   logic [31:0]   src_data_i = '0;
   logic [31:0]   rec_data_i = '0;
   logic [31:0]   q_x_o, q_x_i, dst_data_o;
   logic [15:0]   q_rec1_o, q_rec2_o;

   logic [31:0]   src_mem [WORDS];
   logic [31:0]   rec_mem [WORDS];
   logic [AW+31:0] exp_q [$];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   wr_count = 0;
   int   done_count = 0;
   int   t0 = 0;
   int   wr_base = 0;
   int   lit_mode = 0;
   logic tim_en = 1'b0;

   jpeg_quant_seq #(.WORDS(WORDS), .AW(AW)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .hold_i     (hold_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .src_addr_o (src_addr_o),
      .src_re_o   (src_re_o),
      .src_data_i (src_data_i),
      .rec_addr_o (rec_addr_o),
      .rec_re_o   (rec_re_o),
      .rec_data_i (rec_data_i),
      .q_x_o      (q_x_o),
      .q_rec1_o   (q_rec1_o),
      .q_rec2_o   (q_rec2_o),
      .q_x_i      (q_x_i),
      .dst_addr_o (dst_addr_o),
      .dst_data_o (dst_data_o),
      .dst_we_o   (dst_we_o)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference quantizer ----------------
   // The scaled value is x*rec / 2^17. It is rounded half away from zero, and
   // only the low 16 bits are kept.
   function automatic logic [15:0] quant(input logic [15:0] x, input logic [15:0] r);
      int p, m, y;
      p = int'($signed(x)) * int'($signed(r));
      m = (p < 0) ? -p : p;
      y = (m + 65536) / 131072;
      if (p < 0) y = -y;
      return y[15:0];
   endfunction

   function automatic logic [31:0] quant_word(input logic [31:0] x, input logic [31:0] r);
      return {quant(x[31:16], r[31:16]), quant(x[15:0], r[15:0])};
   endfunction

   // Hand-derived results for the fixed data patterns.
   function automatic logic [31:0] lit_word(input int mode, input logic [AW-1:0] a);
      logic [15:0] pos, neg;
      pos = 16'(32 * int'(a));
      neg = 16'(-32 * int'(a));
      case (mode)
         1:       return 32'h0001_FFFF;
         2:       return a[0] ? 32'h0001_0001 : 32'h0001_FFFF;
         default: return {pos, neg};
      endcase
   endfunction

   // ---------------- RAM and quantizer models ----------------
   always @(posedge clk) begin
      if (src_re_o) src_data_i <= src_mem[src_addr_o];
      if (rec_re_o) rec_data_i <= rec_mem[rec_addr_o];
   end

   assign q_x_i = {quant(q_x_o[31:16], q_rec1_o), quant(q_x_o[15:0], q_rec2_o)};

   // ---------------- checker helper ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      logic [AW+31:0] e;
      int rel;
      rel = cyc - t0;
      if (!rst_i) begin
         check("rec_addr_eq_src", rec_addr_o, src_addr_o);
         check("rec_re_eq_src", rec_re_o, src_re_o);
         if (hold_i) begin
            check("we_low_in_hold", dst_we_o, 0);
            check("re_low_in_hold", src_re_o, 0);
         end
         if (dst_we_o) begin
            wr_count++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0d data 0x%08h, expected no write (cycle %0d)",
                        dst_addr_o, dst_data_o, cyc);
            end else begin
               e = exp_q.pop_front();
               check("dst_addr", dst_addr_o, e[AW+31:32]);
               check("dst_data", dst_data_o, e[31:0]);
            end
            if (lit_mode != 0) check("dst_data_literal", dst_data_o, lit_word(lit_mode, dst_addr_o));
            if (tim_en) check("write_cycle", rel, 2 + (wr_count - wr_base));
         end
         if (done_o) begin
            done_count++;
            if (tim_en) check("done_cycle", rel, 35);
         end
         if (tim_en) check("busy_window", busy_o, (rel >= 1 && rel <= 35));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic fill(input int pat);
      for (int k = 0; k < WORDS; k++) begin
         case (pat)
            1: begin
               src_mem[k] = 32'h0040_FFC0;
               rec_mem[k] = 32'h0800_0800;
            end
            2: begin
               src_mem[k] = (k % 2 == 0) ? 32'h0020_FFE0 : 32'h0030_0030;
               rec_mem[k] = 32'h0800_0800;
            end
            3: begin
               src_mem[k] = {16'(k * 256), 16'(-k * 256)};
               rec_mem[k] = 32'h4000_4000;
            end
            default: begin
               src_mem[k] = $urandom;
               rec_mem[k] = $urandom;
            end
         endcase
         exp_q.push_back({AW'(k), quant_word(src_mem[k], rec_mem[k])});
      end
      lit_mode = (pat <= 3) ? pat : 0;
   endtask

   task automatic run_block(input int pat, input int mode);
      int  base_d, rel, nw, hold_left;
      bit  h1, h2, seen;
      fill(pat);
      @(posedge clk); #1;
      wr_base = wr_count;
      base_d  = done_count;
      t0      = cyc;
      tim_en  = (mode == M_PLAIN || mode == M_START);
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i   = 1'b0;
      hold_left = 0;
      h1 = 0; h2 = 0; seen = 0;
      for (int i = 0; i < 400; i++) begin
         if (done_o) begin
            seen = 1;
            break;
         end
         rel = cyc - t0;
         nw  = wr_count - wr_base;
         case (mode)
            M_START: start_i = (rel >= 5 && rel <= 34) ? 1'($urandom_range(0, 1)) : 1'b0;
            M_RHOLD: hold_i = ($urandom_range(0, 3) == 0);
            M_HOLD: begin
               if (hold_left > 0) begin
                  hold_left--;
                  if (hold_left == 0) hold_i = 1'b0;
               end else if (!h1 && nw >= 10) begin
                  hold_i = 1'b1; hold_left = 3; h1 = 1;
               end else if (!h2 && nw >= 31) begin
                  hold_i = 1'b1; hold_left = 5; h2 = 1;
               end
            end
            default: ;
         endcase
         @(posedge clk); #1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done_o within 400 cycles, expected one");
      end
      // A start or hold during the DONE cycle must not matter.
      start_i = (mode == M_START);
      hold_i  = (mode == M_RHOLD);
      @(posedge clk); #1;
      tim_en  = 1'b0;
      start_i = 1'b0;
      hold_i  = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("writes_per_block", wr_count - wr_base, 32);
      check("done_per_block", done_count - base_d, 1);
      check("exp_queue_drained", exp_q.size(), 0);
      check("idle_after_block", busy_o, 0);
      lit_mode = 0;
      exp_q.delete();
   endtask

   task automatic run_reset_block();
      int base_d;
      fill(4);
      @(posedge clk); #1;
      wr_base = wr_count;
      base_d  = done_count;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (wr_count - wr_base >= 15) break;
         @(posedge clk); #1;
      end
      rst_i = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_src_re", src_re_o, 0);
      check("rst_we", dst_we_o, 0);
      check("rst_src_addr", src_addr_o, 0);
      check("rst_dst_addr", dst_addr_o, 0);
      check("rst_dst_data", dst_data_o, 0);
      @(posedge clk); #1;
      rst_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("writes_before_abort", wr_count - wr_base, 15);
      check("no_done_after_abort", done_count - base_d, 0);
      check("idle_after_abort", busy_o, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      @(negedge clk);
      check("reset_busy", busy_o, 0);
      check("reset_done", done_o, 0);
      check("reset_src_re", src_re_o, 0);
      check("reset_rec_re", rec_re_o, 0);
      check("reset_we", dst_we_o, 0);
      check("reset_src_addr", src_addr_o, 0);
      check("reset_dst_addr", dst_addr_o, 0);
      check("reset_dst_data", dst_data_o, 0);

      // Literal pins of the reference quantizer.
      check("pin_pos_one", quant(16'h0040, 16'h0800), 16'h0001);
      check("pin_neg_one", quant(16'hFFC0, 16'h0800), 16'hFFFF);
      check("pin_pos_half", quant(16'h0020, 16'h0800), 16'h0001);
      check("pin_neg_half", quant(16'hFFE0, 16'h0800), 16'hFFFF);
      check("pin_three_quarter", quant(16'h0030, 16'h0800), 16'h0001);
      check("pin_quarter", quant(16'h0010, 16'h0800), 16'h0000);
      check("pin_neg_three_quarter", quant(16'hFFD0, 16'h0800), 16'hFFFF);
      check("pin_max_max", quant(16'h7FFF, 16'h7FFF), 16'h2000);
      check("pin_min_min", quant(16'h8000, 16'h8000), 16'h2000);
      check("pin_min_max", quant(16'h8000, 16'h7FFF), 16'hE000);

      @(posedge clk); #1;
      rst_i = 1'b0;

      run_block(1, M_PLAIN);
      run_block(2, M_PLAIN);
      run_block(3, M_PLAIN);
      run_block(4, M_HOLD);
      run_block(4, M_START);
      run_block(4, M_RHOLD);
      run_block(4, M_RHOLD);
      run_reset_block();
      run_block(4, M_PLAIN);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
